// File: rtl/wiper_speed_ctrl.sv
// -----------------------------------------------------------------------------
// wiper_speed_ctrl
//
// Rain-driven windshield wiper speed controller.
//
// A free-running prescaler divides clk_2 down to a sample tick. On every
// sample edge the rain-sensor vector is popcounted, and the count is mapped
// to a candidate speed (off / slow / fast). A new speed is committed only
// after the same candidate has been seen on PERSIST consecutive ticks, which
// filters out single-tick glitches on the sensors. A manual override forces
// the speed directly on every clock, and freeze stalls the whole block.
//
// Parameters:
//   NSENS    number of rain-sensor inputs (1..15)
//   DIV      clk_2 cycles per sample tick (>= 2)
//   TH_SLOW  minimum drop count for slow speed
//   TH_FAST  minimum drop count for fast speed
//   PERSIST  consecutive ticks a new candidate must hold before commit (1..15)
//
// Ports:
//   clk_2         in   system clock
//   reset         in   asynchronous active-high reset, clears all state
//   freeze        in   1 = stall prescaler, persistence and manual path
//   rain          in   one bit per sensor, 1 = drop detected
//   manual        in   1 = manual override mode
//   manual_level  in   manual speed request, 3 is treated as 2
//   wiper         out  committed speed: 0 off, 1 slow, 2 fast
//   drop_count    out  popcount of rain captured at the last sample edge
//   sample_tick   out  one-cycle pulse in the cycle after each sample edge
//   changed       out  one-cycle pulse in the cycle after wiper changes
// -----------------------------------------------------------------------------
module wiper_speed_ctrl #(
  parameter int NSENS   = 5,
  parameter int DIV     = 4,
  parameter int TH_SLOW = 3,
  parameter int TH_FAST = 5,
  parameter int PERSIST = 2
) (
  input  logic                           clk_2,
  input  logic                           reset,
  input  logic                           freeze,
  input  logic [NSENS-1:0]               rain,
  input  logic                           manual,
  input  logic [1:0]                     manual_level,
  output logic [1:0]                     wiper,
  output logic [$clog2(NSENS+1)-1:0]     drop_count,
  output logic                           sample_tick,
  output logic                           changed
);

  // Width of the drop counter: wide enough that a popcount of all NSENS
  // sensors can never overflow.
  localparam int CW = $clog2(NSENS + 1);

  // Width of the prescaler; DIV is at least 2 so this is at least 1 bit.
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] TH_SLOW_C  = CW'(TH_SLOW);
  localparam logic [CW-1:0] TH_FAST_C  = CW'(TH_FAST);

  // The persistence counter never needs to exceed PERSIST, which fits in
  // four bits for the whole legal range.
  localparam logic [3:0]    PERSIST_C  = 4'(PERSIST);

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } speed_t;

  logic [PW-1:0] prescaler;
  logic          sample_edge;
  logic [CW-1:0] popcount;
  speed_t        cand;
  speed_t        manual_speed;

  speed_t        state;
  speed_t        state_next;
  speed_t        pending;
  speed_t        pending_next;
  logic [3:0]    pc;
  logic [3:0]    pc_next;
  logic [3:0]    pc_inc;

  // Prescaler: counts 0..DIV-1 while not frozen. Freezing simply holds the
  // current phase, so ticks resume exactly where they left off.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (!freeze) begin
      if (prescaler == PRESC_LAST) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // The clock edge on which the prescaler sits at its last value is the
  // sample edge. Freeze masks it so nothing downstream moves.
  assign sample_edge = !freeze && (prescaler == PRESC_LAST);

  // Population count of the sensor vector.
  always_comb begin
    popcount = '0;
    for (int i = 0; i < NSENS; i++) begin
      popcount = popcount + CW'(rain[i]);
    end
  end

  // Map the drop count to a candidate speed. Fast is checked first so it
  // wins when both thresholds are met.
  always_comb begin
    cand = SPD_OFF;
    if (popcount >= TH_FAST_C) begin
      cand = SPD_FAST;
    end else if (popcount >= TH_SLOW_C) begin
      cand = SPD_SLOW;
    end
  end

  // Manual request decode: level 3 saturates to fast so the wiper output
  // can never show the illegal code 3.
  always_comb begin
    manual_speed = SPD_OFF;
    case (manual_level)
      2'd0:    manual_speed = SPD_OFF;
      2'd1:    manual_speed = SPD_SLOW;
      default: manual_speed = SPD_FAST;
    endcase
  end

  assign pc_inc = pc + 4'd1;

  // Speed state register together with the persistence bookkeeping
  // (pending candidate and how many consecutive ticks it has been seen).
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state   <= SPD_OFF;
      pending <= SPD_OFF;
      pc      <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      pc      <= pc_next;
    end
  end

  // Next-state logic. Manual mode overrides the wiper on every clock and
  // keeps the persistence counter cleared, so returning to auto always
  // starts a fresh persistence window. In auto mode the speed only moves on
  // sample edges, and a candidate must repeat PERSIST times in a row; a
  // different candidate in between restarts the count from one. Any speed
  // can jump directly to any other, including off straight to fast.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    pc_next      = pc;
    if (!freeze) begin
      if (manual) begin
        state_next = manual_speed;
        pc_next    = '0;
      end else if (sample_edge) begin
        if (cand == state) begin
          pc_next = '0;
        end else if ((pc == 4'd0) || (cand != pending)) begin
          pending_next = cand;
          if (PERSIST_C == 4'd1) begin
            state_next = cand;
            pc_next    = '0;
          end else begin
            pc_next = 4'd1;
          end
        end else begin
          if (pc_inc == PERSIST_C) begin
            state_next = cand;
            pc_next    = '0;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
    end
  end

  // Registered status outputs. They update on the same edge as the speed
  // state so everything a sample produces becomes visible together one
  // cycle later. Both pulses naturally drop to zero while frozen because
  // neither a sample edge nor a speed change can happen then.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      drop_count  <= '0;
      sample_tick <= 1'b0;
      changed     <= 1'b0;
    end else begin
      if (sample_edge) begin
        drop_count <= popcount;
      end
      sample_tick <= sample_edge;
      changed     <= (state_next != state);
    end
  end

  assign wiper = state;

endmodule

// File: tb/tb_wiper_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wiper_speed_ctrl
//
// Directed testbench for wiper_speed_ctrl with default parameters
// (NSENS=5, DIV=4, TH_SLOW=3, TH_FAST=5, PERSIST=2). Cycle k means the
// interval after the k-th rising edge following reset release; all inputs
// change and all outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wiper_speed_ctrl;

  logic       clk_2;
  logic       reset;
  logic       freeze;
  logic [4:0] rain;
  logic       manual;
  logic [1:0] manual_level;
  logic [1:0] wiper;
  logic [2:0] drop_count;
  logic       sample_tick;
  logic       changed;

  int testsRun;
  int failCount;

  wiper_speed_ctrl #(
    .NSENS   (5),
    .DIV     (4),
    .TH_SLOW (3),
    .TH_FAST (5),
    .PERSIST (2)
  ) dut (
    .clk_2        (clk_2),
    .reset        (reset),
    .freeze       (freeze),
    .rain         (rain),
    .manual       (manual),
    .manual_level (manual_level),
    .wiper        (wiper),
    .drop_count   (drop_count),
    .sample_tick  (sample_tick),
    .changed      (changed)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // Drive all functional inputs at once.
  task automatic applyStimulus(input logic fz, input logic [4:0] r,
                               input logic m, input logic [1:0] lvl);
    freeze       = fz;
    rain         = r;
    manual       = m;
    manual_level = lvl;
  endtask

  // One comparison: counts it, and on mismatch counts the failure and
  // reports the tag with observed and expected values.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n cycles, landing on a falling edge.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b1;
    applyStimulus(1'b0, 5'b00000, 1'b0, 2'd0);
    waitCycles(2);

    // Reset state
    checkOutput("rst_wiper", 8'(wiper), 8'd0);
    checkOutput("rst_drop", 8'(drop_count), 8'd0);
    checkOutput("rst_tick", 8'(sample_tick), 8'd0);
    checkOutput("rst_changed", 8'(changed), 8'd0);

    // Slow rain held from reset: tick 1 in cycle 4, commit at tick 2
    applyStimulus(1'b0, 5'b00111, 1'b0, 2'd0);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("t2_tick_c3", 8'(sample_tick), 8'd0);
    waitCycles(1);
    checkOutput("t2_tick_c4", 8'(sample_tick), 8'd1);
    checkOutput("t2_drop_c4", 8'(drop_count), 8'd3);
    checkOutput("t2_wiper_c4", 8'(wiper), 8'd0);
    checkOutput("t2_changed_c4", 8'(changed), 8'd0);
    waitCycles(3);
    checkOutput("t2_wiper_c7", 8'(wiper), 8'd0);
    checkOutput("t2_tick_c7", 8'(sample_tick), 8'd0);
    waitCycles(1);
    checkOutput("t2_wiper_c8", 8'(wiper), 8'd1);
    checkOutput("t2_changed_c8", 8'(changed), 8'd1);
    checkOutput("t2_tick_c8", 8'(sample_tick), 8'd1);
    waitCycles(1);
    checkOutput("t2_changed_c9", 8'(changed), 8'd0);
    checkOutput("t2_wiper_c9", 8'(wiper), 8'd1);

    // Drive to fast, then leave one pending tick (pc=1) before reset
    applyStimulus(1'b0, 5'b11111, 1'b0, 2'd0);
    waitCycles(3);
    checkOutput("t1_wiper_c12", 8'(wiper), 8'd1);
    checkOutput("t1_drop_c12", 8'(drop_count), 8'd5);
    waitCycles(4);
    checkOutput("t1_wiper_c16", 8'(wiper), 8'd2);
    checkOutput("t1_changed_c16", 8'(changed), 8'd1);
    applyStimulus(1'b0, 5'b00001, 1'b0, 2'd0);
    waitCycles(4);
    checkOutput("t1_wiper_c20", 8'(wiper), 8'd2);
    checkOutput("t1_tick_c20", 8'(sample_tick), 8'd1);
    checkOutput("t1_drop_c20", 8'(drop_count), 8'd1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t1_async_wiper", 8'(wiper), 8'd0);
    checkOutput("t1_async_drop", 8'(drop_count), 8'd0);
    checkOutput("t1_async_tick", 8'(sample_tick), 8'd0);
    checkOutput("t1_async_changed", 8'(changed), 8'd0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 2'd0);
    @(negedge clk_2);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("t1_rel_tick_c3", 8'(sample_tick), 8'd0);
    checkOutput("t1_rel_wiper_c3", 8'(wiper), 8'd0);
    waitCycles(1);
    checkOutput("t1_rel_tick_c4", 8'(sample_tick), 8'd1);

    // Glitches: single fast ticks separated by a dry tick never commit
    applyStimulus(1'b0, 5'b11111, 1'b0, 2'd0);
    waitCycles(4);
    checkOutput("t3_drop_c8", 8'(drop_count), 8'd5);
    checkOutput("t3_wiper_c8", 8'(wiper), 8'd0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 2'd0);
    for (int c = 9; c <= 20; c++) begin
      waitCycles(1);
      checkOutput("t3_changed", 8'(changed), 8'd0);
      checkOutput("t3_wiper", 8'(wiper), 8'd0);
      if (c == 12) applyStimulus(1'b0, 5'b11111, 1'b0, 2'd0);
      if (c == 16) applyStimulus(1'b0, 5'b00000, 1'b0, 2'd0);
    end

    // Manual override with level 3, then release to auto with no rain
    applyStimulus(1'b0, 5'b00000, 1'b1, 2'd3);
    waitCycles(1);
    checkOutput("t5_wiper_c21", 8'(wiper), 8'd2);
    checkOutput("t5_changed_c21", 8'(changed), 8'd1);
    waitCycles(1);
    checkOutput("t5_wiper_c22", 8'(wiper), 8'd2);
    checkOutput("t5_changed_c22", 8'(changed), 8'd0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 2'd0);
    waitCycles(2);
    checkOutput("t5_wiper_c24", 8'(wiper), 8'd2);
    checkOutput("t5_tick_c24", 8'(sample_tick), 8'd1);
    waitCycles(3);
    checkOutput("t5_wiper_c27", 8'(wiper), 8'd2);
    checkOutput("t5_changed_c27", 8'(changed), 8'd0);
    waitCycles(1);
    checkOutput("t5_wiper_c28", 8'(wiper), 8'd0);
    checkOutput("t5_changed_c28", 8'(changed), 8'd1);

    // Candidate switch slow -> fast restarts persistence, then OFF -> FAST
    applyStimulus(1'b0, 5'b00111, 1'b0, 2'd0);
    waitCycles(4);
    checkOutput("t4_wiper_c32", 8'(wiper), 8'd0);
    checkOutput("t4_drop_c32", 8'(drop_count), 8'd3);
    applyStimulus(1'b0, 5'b11111, 1'b0, 2'd0);
    waitCycles(4);
    checkOutput("t4_wiper_c36", 8'(wiper), 8'd0);
    checkOutput("t4_drop_c36", 8'(drop_count), 8'd5);
    waitCycles(4);
    checkOutput("t4_wiper_c40", 8'(wiper), 8'd2);
    checkOutput("t4_changed_c40", 8'(changed), 8'd1);

    // Manual level 0 brings the wiper off in one cycle
    applyStimulus(1'b0, 5'b11111, 1'b1, 2'd0);
    waitCycles(1);
    checkOutput("t6_wiper_c41", 8'(wiper), 8'd0);
    checkOutput("t6_changed_c41", 8'(changed), 8'd1);

    // Freeze for 20 cycles with heavy rain and a manual fast request
    applyStimulus(1'b1, 5'b11111, 1'b1, 2'd2);
    for (int c = 42; c <= 61; c++) begin
      waitCycles(1);
      checkOutput("t6_frz_tick", 8'(sample_tick), 8'd0);
      checkOutput("t6_frz_wiper", 8'(wiper), 8'd0);
      checkOutput("t6_frz_changed", 8'(changed), 8'd0);
    end
    applyStimulus(1'b0, 5'b11111, 1'b0, 2'd0);
    waitCycles(2);
    checkOutput("t6_tick_c63", 8'(sample_tick), 8'd0);
    waitCycles(1);
    checkOutput("t6_tick_c64", 8'(sample_tick), 8'd1);
    checkOutput("t6_drop_c64", 8'(drop_count), 8'd5);
    checkOutput("t6_wiper_c64", 8'(wiper), 8'd0);
    waitCycles(3);
    checkOutput("t6_wiper_c67", 8'(wiper), 8'd0);
    waitCycles(1);
    checkOutput("t6_wiper_c68", 8'(wiper), 8'd2);
    checkOutput("t6_changed_c68", 8'(changed), 8'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/wiper_speed_ctrl.md
# wiper_speed_ctrl

Parametrised rain-driven windshield wiper controller. It samples an NSENS-wide rain-sensor vector on an internal prescaled tick and counts active drops. It maps that count to a wiper speed (off / slow / fast) and commits a new speed only after it persists for PERSIST consecutive ticks. It also provides a manual override and a freeze input that stalls all activity. It sits between the board switches (rain, mode, freeze) and the LED/segment outputs driving the wiper indication.

## Interface

Parameters:
- NSENS, 5, number of rain-sensor inputs (1..15)
- DIV, 4, clk_2 cycles per sample tick (≥2)
- TH_SLOW, 3, minimum drop count for slow speed (1..NSENS)
- TH_FAST, 5, minimum drop count for fast speed (TH_SLOW..NSENS)
- PERSIST, 2, consecutive ticks a new candidate must hold before commit (1..15)

Ports (one clock; reset is asynchronous and active-high):
- clk_2  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- freeze  in  1  1 = stall prescaler, persistence, manual path; all outputs hold
- rain  in  NSENS  one bit per sensor, 1 = drop detected
- manual  in  1  1 = manual override mode
- manual_level  in  2  manual speed; 3 treated as 2
- wiper  out  2  committed speed: 0 off, 1 slow, 2 fast (never 3)
- drop_count  out  $clog2(NSENS+1)  popcount of rain captured at last tick
- sample_tick  out  1  one-cycle pulse, high in the cycle after each sample edge
- changed  out  1  one-cycle pulse, high in the cycle after wiper changes value

## Operation

- Reset (async, any time): prescaler=0, pc=0, pending=0, wiper=0, drop_count=0, sample_tick=0, changed=0. Takes effect without a clock edge.
- Prescaler: counts 0..DIV-1 on each clk_2 edge while freeze=0; wraps to 0. The edge at which it equals DIV-1 is a sample edge.
- Sample edge: drop_count ← popcount(rain); sample_tick←1 for one cycle.
- Candidate: cand = 2 if popcount ≥ TH_FAST, else 1 if popcount ≥ TH_SLOW, else 0. Computed from rain at the sample edge.
- States: OFF(0), SLOW(1), FAST(2). Any state may transition directly to any other, so OFF→FAST is legal.
- Auto mode (manual=0), at each sample edge:
  - cand == wiper: pc←0.
  - cand ≠ wiper and (pc == 0 or cand ≠ pending): pending←cand, pc←1; commit if PERSIST == 1.
  - cand ≠ wiper and cand == pending and pc ≠ 0: pc←pc+1; commit if pc+1 == PERSIST.
  - Commit: wiper←cand, pc←0, changed←1 next cycle.
- Manual mode (manual=1, freeze=0): on every clk_2 edge, not tick-gated, wiper←min(manual_level,2) and pc←0. changed pulses when the value differs. Prescaler and drop_count keep running.
- Manual→auto: wiper keeps its manual value; persistence restarts from pc=0.
- Freeze=1: no state changes at all, and freeze overrides manual. sample_tick and changed are 0 while frozen. The prescaler resumes from its held value.
- Sensor count width: popcount never overflows drop_count.

## Timing

- Sample-to-output latency: 1 cycle. drop_count, sample_tick, wiper and changed all update at the same sample edge.
- Out of reset with freeze=0: first sample edge is the DIV-th rising edge, so sample_tick is high in cycle DIV.
- Minimum auto reaction: PERSIST ticks = PERSIST·DIV cycles after rain becomes stable, counted from the first sample edge that sees it.
- Manual reaction: 1 cycle.
- Simultaneous manual=1 and sample edge: manual wins for wiper. drop_count/sample_tick still update.
- changed never stays high 2 cycles unless wiper changes on consecutive edges, which is possible only in manual mode.

## Test plan

Defaults: NSENS=5, DIV=4, TH_SLOW=3, TH_FAST=5, PERSIST=2.

1. Reset mid-run (wiper=2, pc=1): assert reset between edges -> wiper=0, drop_count=0, sample_tick=0, changed=0 immediately. Release -> sample_tick first high in cycle 4.
2. rain=5'b00111 held from reset -> drop_count=3 after tick 1. wiper=1 after tick 2 (cycle 8), with a changed pulse in cycle 8 only.
3. Glitch: rain=5'b11111 for one tick, then 5'b00000 -> wiper stays 0, changed never pulses, pc returns to 0.
4. Candidate switch: from wiper=0, 3 drops at tick 1, then 5 drops at ticks 2 and 3 -> wiper stays 0 after tick 2. wiper=2 after tick 3 (direct OFF→FAST).
5. Manual: manual=1, manual_level=3 -> wiper=2 one cycle later, one changed pulse. Release manual with rain=0 -> wiper=0 exactly 2 ticks later.
6. Freeze: wiper=0, rain=5'b11111, freeze=1 for 20 cycles -> no sample_tick, wiper=0, prescaler held. Release -> ticks resume from the held phase, and wiper=2 after 2 ticks.
